debounce_ctrl: RTL and testbench
================================

# debounce_ctrl

Debounce controller for a mechanical push-button or switch input. It owns a mod-Limit settle timer and sequences it with a four-state FSM. It emits a clean level plus single-cycle rise and fall strobes. It sits between the raw board pin and downstream logic such as counters and FSMs.

## Interface
- Limit, default 1_000_000: settle time in clk_i cycles (10 ms at 100 MHz); must be ≥ 2.
- Width, default 20: timer width; must satisfy 2^Width ≥ Limit.
- clk_i  input  1  system clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-high.
- btn_i  input  1  raw, bouncy, possibly asynchronous button level.
- db_o  output  1  debounced level; registered.
- rise_o  output  1  one-cycle strobe when db_o goes 0→1; registered.
- fall_o  output  1  one-cycle strobe when db_o goes 1→0; registered.
- busy_o  output  1  high while the FSM is in WAIT1 or WAIT0 (settling).

## Operation
- Reset values:
  - state ZERO; timer 0.
  - db_o, rise_o, fall_o and busy_o are 0.
  - Synchronizer flops are 0.
- in_s is the sampled input: the synchronizer output when it is compiled in, else btn_i directly.
- Timer: cleared to 0 on every FSM entry into WAIT1 or WAIT0. It increments by 1 per cycle while in a wait state. done = (cnt == Limit-1). It never wraps in normal use.
- ZERO (db_o=0):
  - in_s=1 → WAIT1, timer cleared.
- WAIT1 (db_o=0, busy_o=1):
  - in_s=0 → ZERO. This is the bounce-abort path.
  - done and in_s=1 → ONE, with rise_o=1 for that one cycle.
  - Otherwise stay.
- ONE (db_o=1):
  - in_s=0 → WAIT0, timer cleared.
- WAIT0 (db_o=1, busy_o=1):
  - in_s=1 → ONE.
  - done and in_s=0 → ZERO, with fall_o=1 for that one cycle.
  - Otherwise stay.
- Abort takes priority over done: if in_s disagrees in the same cycle that done is true, the FSM aborts.
- rise_o and fall_o are never high together and never high on consecutive cycles.

## Timing
- Without sync: with edge 1 being the first edge that samples in_s=1 in ZERO, db_o and rise_o change at edge Limit+1.
- With sync: count edges from the first edge after btn_i changes. db_o changes at edge Limit+3 (2 extra cycles of synchronizer latency).
- The same latency applies symmetrically to release.
- A bounce of any length, i.e. one sample of the opposite level during a wait state, restarts the full settle period from the next qualifying sample.
- Reset mid-settle: all state and outputs return to reset values immediately (asynchronous). A held-high input then requires a full settle after reset releases; no strobe fires due to reset.

## Configuration
- DEBOUNCE_SYNC_EN defined: a 2-flop synchronizer on btn_i feeds in_s. This adds 2 cycles of latency.
- DEBOUNCE_SYNC_EN undefined: btn_i is used directly. The caller guarantees btn_i is already synchronous to clk_i.

## Structure
- A shared header, debounce_defs.vh, holds:
  - state encodings ST_ZERO=2'd0, ST_WAIT1=2'd1, ST_ONE=2'd2, ST_WAIT0=2'd3;
  - the default Limit and Width constants.
- Sub-module settle_timer(Width, Limit), with ports clk_i, rst_i, clr_i, en_i, done_o. It is a counter with synchronous clear and a terminal-count flag.
- debounce_ctrl instantiates one settle_timer and contains the FSM, the output registers and the optional synchronizer.

## Test plan
All scenarios use Limit=4, Width=3, with DEBOUNCE_SYNC_EN defined unless stated otherwise.
- Reset: assert rst_i asynchronously mid-cycle → db_o, rise_o, fall_o and busy_o are 0 immediately, and remain 0 with btn_i=0 for 20 cycles.
- Clean press: btn_i 0→1, held 12 cycles → db_o rises at edge 7, rise_o high exactly one cycle, and busy_o high during edges 3–6.
- Bounce press: btn_i high 2 cycles, low 1 cycle, then held high → no rise_o during the bounce; db_o rises 7 edges after the final 0→1 transition.
- Clean release from ONE: btn_i 1→0, held → db_o falls at edge 7 and fall_o pulses once; rise_o stays 0.
- Glitch rejection: in ZERO, btn_i high for 3 cycles then low → db_o stays 0, no strobes, busy_o returns to 0.
- Reset mid-settle: assert rst_i while in WAIT1 with btn_i held high → outputs reset; after release, db_o rises exactly 7 edges later, with one rise_o pulse.
- Repeat the clean-press scenario with DEBOUNCE_SYNC_EN undefined → db_o rises at edge 5.

Source files
------------

// File: rtl/debounce_ctrl_pkg.sv
// Shared definitions for debounce_ctrl: FSM state encodings and default timing constants.
package debounce_ctrl_pkg;

  typedef enum logic [1:0] {
    StZero  = 2'd0,
    StWait1 = 2'd1,
    StOne   = 2'd2,
    StWait0 = 2'd3
  } db_state_e;

  // 10 ms at 100 MHz; 2^20 covers it.
  localparam int unsigned DefLimit = 1_000_000;
  localparam int unsigned DefWidth = 20;

endpackage

// File: rtl/settle_timer.sv
// Settle timer: up-counter with synchronous clear and a terminal-count flag at Limit-1.
module settle_timer
  import debounce_ctrl_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Limit = DefLimit
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [Width-1:0] LastCnt = Width'(Limit - 1);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LastCnt);

endmodule

// File: rtl/debounce_ctrl.sv
// Button debouncer: four-state settle FSM with clean level and rise/fall strobes.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer on btn_i.
module debounce_ctrl
  import debounce_ctrl_pkg::*;
#(
  parameter int unsigned Limit = DefLimit,
  parameter int unsigned Width = DefWidth
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  logic      in_s;
  logic      tmr_clr, tmr_en, tmr_done;
  db_state_e state_d, state_q;
  logic      db_d, db_q;
  logic      rise_d, rise_q;
  logic      fall_d, fall_q;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[0], btn_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign in_s = sync_q[1];
`else
  assign in_s = btn_i;
`endif

  settle_timer #(
    .Width (Width),
    .Limit (Limit)
  ) u_settle_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  assign tmr_en = (state_q == StWait1) || (state_q == StWait0);

  // A disagreeing sample aborts the wait even when done is set in the same cycle.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StZero: begin
        if (in_s) begin
          state_d = StWait1;
          tmr_clr = 1'b1;
        end
      end
      StWait1: begin
        if (!in_s) begin
          state_d = StZero;
        end else if (tmr_done) begin
          state_d = StOne;
          rise_d  = 1'b1;
        end
      end
      StOne: begin
        if (!in_s) begin
          state_d = StWait0;
          tmr_clr = 1'b1;
        end
      end
      StWait0: begin
        if (in_s) begin
          state_d = StOne;
        end else if (tmr_done) begin
          state_d = StZero;
          fall_d  = 1'b1;
        end
      end
      default: state_d = StZero;
    endcase
    db_d = (state_d == StOne) || (state_d == StWait0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StZero;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = tmr_en;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl: run-length reference model checked every cycle plus directed edge checks.
module tb_debounce_ctrl;

  localparam int unsigned Limit = 4;
  localparam int unsigned Width = 3;
`ifdef DEBOUNCE_SYNC_EN
  localparam int Lat     = 2;
  localparam int ExpEdge = 7;
`else
  localparam int Lat     = 0;
  localparam int ExpEdge = 5;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic btn_i = 1'b0;
  logic db_o, rise_o, fall_o, busy_o;

  always #5 clk_i = ~clk_i;

  debounce_ctrl #(
    .Limit (Limit),
    .Width (Width)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i),
    .db_o   (db_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .busy_o (busy_o)
  );

  // Reference: the level flips once Limit+1 consecutive samples disagree with it.
  logic m_s1, m_s2, m_in, m_db, m_rise, m_fall;
  int   m_run;

`ifdef DEBOUNCE_SYNC_EN
  assign m_in = m_s2;
`else
  assign m_in = btn_i;
`endif

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_db <= 1'b0;
      m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0;
    end else begin
      m_s1   <= btn_i;
      m_s2   <= m_s1;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      if (m_in != m_db) begin
        if (m_run == int'(Limit)) begin
          m_db   <= m_in;
          m_rise <= m_in;
          m_fall <= !m_in;
          m_run  <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int n_rise = 0;
  int n_fall = 0;
  int edges;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare all outputs with the model.
  task automatic tick();
    @(negedge clk_i);
    chk("model_db", db_o, m_db);
    chk("model_rise", rise_o, m_rise);
    chk("model_fall", fall_o, m_fall);
    chk("model_busy", busy_o, m_run != 0);
    n_rise += int'(rise_o);
    n_fall += int'(fall_o);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic measure(input logic level, output int e);
    e = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (db_o === level) begin
        e = i;
        break;
      end
    end
  endtask

  initial begin
    // Reset behaviour
    #1;
    chk("por_db", db_o, 1'b0);
    chk("por_busy", busy_o, 1'b0);
    tick_n(3);
    rst_i = 1'b0;
    tick_n(3);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_db", db_o, 1'b0);
    chk("rst_rise", rise_o, 1'b0);
    chk("rst_fall", fall_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    tick_n(2);
    rst_i = 1'b0;
    n_rise = 0; n_fall = 0;
    tick_n(20);
    chk("idle_db", db_o, 1'b0);
    chk_int("idle_strobes", n_rise + n_fall, 0);

    // Clean press
    n_rise = 0;
    btn_i  = 1'b1;
    edges  = -1;
    for (int i = 1; i <= 30 && edges < 0; i++) begin
      tick();
      if (i < ExpEdge) chk("press_busy", busy_o, i > Lat);
      if (db_o === 1'b1) edges = i;
    end
    chk_int("press_edge", edges, ExpEdge);
    chk("press_rise_at_edge", rise_o, 1'b1);
    tick();
    chk("press_rise_once", rise_o, 1'b0);
    tick_n(12 - ExpEdge - 1);
    chk_int("press_rise_count", n_rise, 1);

    // Clean release
    n_rise = 0; n_fall = 0;
    btn_i = 1'b0;
    measure(1'b0, edges);
    chk_int("release_edge", edges, ExpEdge);
    chk("release_fall_at_edge", fall_o, 1'b1);
    tick_n(6);
    chk_int("release_fall_count", n_fall, 1);
    chk_int("release_rise_count", n_rise, 0);

    // Bounce on press
    n_rise = 0;
    btn_i = 1'b1;
    tick_n(2);
    btn_i = 1'b0;
    tick();
    btn_i = 1'b1;
    measure(1'b1, edges);
    chk_int("bounce_edge", edges, ExpEdge);
    chk_int("bounce_rise_count", n_rise, 1);
    btn_i = 1'b0;
    tick_n(12);
    chk("bounce_back_low", db_o, 1'b0);

    // Glitch rejection
    n_rise = 0; n_fall = 0;
    btn_i = 1'b1;
    tick_n(3);
    btn_i = 1'b0;
    tick_n(12);
    chk("glitch_db", db_o, 1'b0);
    chk("glitch_busy", busy_o, 1'b0);
    chk_int("glitch_strobes", n_rise + n_fall, 0);

    // Reset mid-settle
    btn_i = 1'b1;
    tick_n(4);
    chk("midrst_busy_before", busy_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_db", db_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_rise", rise_o, 1'b0);
    tick();
    rst_i  = 1'b0;
    n_rise = 0;
    measure(1'b1, edges);
    chk_int("midrst_edge", edges, ExpEdge);
    tick_n(5);
    chk_int("midrst_rise_count", n_rise, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
